// File: rtl/audio_fft_framer_pkg.sv
// Shared types and widths for the audio FFT framer and its AXI-Stream interface.
package fft_pkg;

  localparam int FFT_DATA_W = 32;
  localparam int FFT_HALF_W = 16;

  typedef struct packed {
    logic [FFT_HALF_W-1:0] im;
    logic [FFT_HALF_W-1:0] re;
  } fft_cplx_t;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} framer_rd_state_t;

  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_READING} bank_state_t;

  // A bank can accept samples while it is empty (first write) or already filling.
  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/audio_fft_framer_if.sv
// AXI-Stream link carrying complex FFT input beats from the framer to the FFT core.
interface audio_fft_framer_if;
  import fft_pkg::*;

  logic [FFT_DATA_W-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/audio_fft_framer_pingpong_bram.sv
// Simple dual-port sample RAM holding both ping-pong banks; address = {bank, index}.
module pingpong_bram #(
  parameter int DEPTH  = 2048,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one sample stored per accepted strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds its value until the next read is issued.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_fft_framer.sv
// Collects audio samples into ping-pong frames and streams each frame as AXIS complex beats.
module audio_fft_framer
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int SAMPLE_W  = 8,
  parameter int SIGNED_IN = 0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  audio_fft_framer_if.master  m_axis,
  output logic                overflow_out,
  output logic [15:0]         drop_count_out,
  output logic                busy_out
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  framer_rd_state_t state_q, state_d;

  logic                a_valid_q, a_last_q;
  logic                b_valid_q, b_last_q;
  logic [SAMPLE_W-1:0] b_data_q;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic [SAMPLE_W-1:0] head_data;
  logic [SAMPLE_W-1:0] head_signed;
  logic                head_last;
  logic                out_valid;
  logic                wr_fire, drop, pop, rd_issue, rd_done, move_ab;
  fft_cplx_t           beat;

  // Output head: the skid entry is older than the RAM output register, so it goes first.
  always_comb begin
    head_data = b_valid_q ? b_data_q : ram_rdata;
    head_last = b_valid_q ? b_last_q : a_last_q;
  end

  assign out_valid = a_valid_q | b_valid_q;
  assign pop       = out_valid & m_axis.tready;
  assign rd_done   = pop & head_last;
  assign wr_fire   = sample_valid_in & bank_writable(bank_q[wr_bank_q]);
  assign drop      = sample_valid_in & ~wr_fire;
  assign move_ab   = rd_issue & a_valid_q & ~(pop & ~b_valid_q);

  // Read FSM and bank bookkeeping; read-side transitions first, write side sees their result.
  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    state_d   = state_q;
    rd_issue  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bank_q[rd_bank_q] == BANK_FULL) begin
          bank_d[rd_bank_q] = BANK_READING;
          rd_cnt_d          = '0;
          state_d           = PRIME;
        end
      end
      PRIME, STREAM: begin
        rd_issue = (rd_cnt_q != FRAME_CNT) && (!a_valid_q || !b_valid_q || pop);
        if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
        if (state_q == PRIME) state_d = STREAM;
        if (rd_done) begin
          bank_d[rd_bank_q] = BANK_EMPTY;
          rd_bank_d         = ~rd_bank_q;
          if (bank_q[~rd_bank_q] == BANK_FULL) begin
            bank_d[~rd_bank_q] = BANK_READING;
            rd_cnt_d           = '0;
            state_d            = PRIME;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_fire) begin
      bank_d[wr_bank_q] = BANK_FILLING;
      wr_idx_d          = wr_idx_q + 1'b1;
      if (wr_idx_q == LAST_IDX) begin
        bank_d[wr_bank_q] = BANK_FULL;
        wr_idx_d          = '0;
        if (bank_d[~wr_bank_q] == BANK_EMPTY) begin
          bank_d[~wr_bank_q] = BANK_FILLING;
          wr_bank_d          = ~wr_bank_q;
        end
      end
    end

    if (rd_done && !bank_writable(bank_d[wr_bank_d])) begin
      bank_d[rd_bank_q] = BANK_FILLING;
      wr_bank_d         = rd_bank_q;
      wr_idx_d          = '0;
    end
  end

  // State register for banks, write pointer and read FSM.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank_q    <= '{BANK_EMPTY, BANK_EMPTY};
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      state_q   <= IDLE;
    end else begin
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      state_q   <= state_d;
    end
  end

  // Two-entry output pipe: RAM output register plus one skid entry, so stalls lose nothing.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_last_q  <= 1'b0;
      b_data_q  <= '0;
    end else begin
      if (rd_issue) begin
        a_valid_q <= 1'b1;
        a_last_q  <= (rd_cnt_q[IDX_W-1:0] == LAST_IDX);
      end else if (pop && !b_valid_q) begin
        a_valid_q <= 1'b0;
      end
      if (move_ab) begin
        b_valid_q <= 1'b1;
        b_data_q  <= ram_rdata;
        b_last_q  <= a_last_q;
      end else if (pop && b_valid_q) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Dropped-sample pulse and saturating drop counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      overflow_out   <= 1'b0;
      drop_count_out <= '0;
    end else begin
      overflow_out <= drop;
      if (drop && (drop_count_out != 16'hFFFF)) drop_count_out <= drop_count_out + 1'b1;
    end
  end

  // Convert the head sample to signed and left-justify it into the real half.
  always_comb begin
    head_signed = head_data;
    if (SIGNED_IN == 0) head_signed[SAMPLE_W-1] = ~head_data[SAMPLE_W-1];
    beat.im = '0;
    beat.re = FFT_HALF_W'(head_signed) << (FFT_HALF_W - SAMPLE_W);
  end

  // Busy whenever a frame is queued or being streamed.
  always_comb begin
    busy_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ((bank_q[i] == BANK_FULL) || (bank_q[i] == BANK_READING)) busy_out = 1'b1;
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? beat : '0;
  assign m_axis.tlast  = out_valid & head_last;

  pingpong_bram #(
    .DEPTH (2 * FRAME_LEN),
    .WIDTH (SAMPLE_W),
    .ADDR_W(IDX_W + 1)
  ) u_bram (
    .clk  (clk_in),
    .we   (wr_fire),
    .waddr({wr_bank_q, wr_idx_q}),
    .wdata(sample_in),
    .re   (rd_issue),
    .raddr({rd_bank_q, rd_cnt_q[IDX_W-1:0]}),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_audio_fft_framer.sv
// Scoreboard bench for audio_fft_framer with FRAME_LEN=8, SAMPLE_W=8, offset-binary input.
module tb_audio_fft_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sample;
  logic        sv;
  logic        ovf;
  logic [15:0] dc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int beats_seen = 0;
  int ovf_count  = 0;
  int cyc        = 0;
  int beat_cyc[$];
  logic [32:0] exp_q[$];

  logic        held_v = 1'b0;
  logic [31:0] held_d;
  logic        held_l;

  logic [7:0]  conv_in  [8] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'h81, 8'h40, 8'hC0};
  logic [31:0] conv_exp [8] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_8000, 32'h0000_8100,
                                32'h0000_FF00, 32'h0000_0100, 32'h0000_C000, 32'h0000_4000};

  audio_fft_framer_if axis ();

  audio_fft_framer #(
    .FRAME_LEN(8),
    .SAMPLE_W (8),
    .SIGNED_IN(0)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .sample_in      (sample),
    .sample_valid_in(sv),
    .m_axis         (axis),
    .overflow_out   (ovf),
    .drop_count_out (dc),
    .busy_out       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] expBeat(input logic [7:0] s);
    return {16'h0000, ~s[7], s[6:0], 8'h00};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event did not occur as required", name);
  endtask

  // Called at posedge+1: drives one strobe, then idles so strobes are 'gap' cycles apart.
  task automatic applyStimulus(input logic [7:0] s, input int gap);
    sample = s;
    sv     = 1'b1;
    @(posedge clk); #1;
    sv     = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pushFrame(input logic [7:0] first);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = first + 8'(i);
      exp_q.push_back({(i == 7), expBeat(v)});
    end
  endtask

  task automatic strobeFrame(input logic [7:0] first, input int gap);
    for (int i = 0; i < 8; i++) applyStimulus(first + 8'(i), gap);
  endtask

  task automatic waitBeats(input int target, input int max_cyc, input string name);
    int c;
    c = 0;
    while (beats_seen < target && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    if (beats_seen < target) failNow(name);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks holds while stalled.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checkOutput("stall_valid_held", 32'(axis.tvalid), 32'd1);
        checkOutput("stall_data_stable", axis.tdata, held_d);
        checkOutput("stall_last_stable", 32'(axis.tlast), 32'(held_l));
      end
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          failNow("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", axis.tdata, e[31:0]);
          checkOutput("beat_last", 32'(axis.tlast), 32'(e[32]));
        end
        beats_seen++;
        beat_cyc.push_back(cyc);
      end
      held_v = axis.tvalid && !axis.tready;
      held_d = axis.tdata;
      held_l = axis.tlast;
    end
  end

  // Counts overflow pulses.
  always @(negedge clk) begin
    if (ovf) ovf_count++;
  end

  initial begin
    int base;
    int ovf_base;
    logic [3:0] pat;
    rst_n       = 1'b0;
    sv          = 1'b0;
    sample      = 8'h00;
    axis.tready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_tvalid", 32'(axis.tvalid), 32'd0);
    checkOutput("reset_tlast", 32'(axis.tlast), 32'd0);
    checkOutput("reset_tdata", axis.tdata, 32'd0);
    checkOutput("reset_overflow", 32'(ovf), 32'd0);
    checkOutput("reset_drop_count", 32'(dc), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Conversion and single frame with tready=1, strobes every 4 cycles
    $display("[TB] conversion / single frame");
    axis.tready = 1'b1;
    base = beats_seen;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), conv_exp[i]});
    for (int i = 0; i < 7; i++) applyStimulus(conv_in[i], 4);
    applyStimulus(conv_in[7], 1);
    @(negedge clk);
    checkOutput("latency_cycle0_tvalid", 32'(axis.tvalid), 32'd0);
    checkOutput("latency_cycle0_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("latency_cycle1_tvalid", 32'(axis.tvalid), 32'd0);
    @(negedge clk);
    checkOutput("latency_cycle2_tvalid", 32'(axis.tvalid), 32'd1);
    waitBeats(base + 8, 100, "single_frame_timeout");
    #1;
    checkOutput("single_frame_done_busy", 32'(busy), 32'd0);
    checkOutput("single_frame_done_tvalid", 32'(axis.tvalid), 32'd0);
    if (beat_cyc.size() >= base + 8)
      checkOutput("single_frame_consecutive", 32'(beat_cyc[base+7] - beat_cyc[base]), 32'd7);
    else
      failNow("single_frame_beat_count");

    // Backpressure with tready pattern 1,0,0,1
    $display("[TB] backpressure");
    @(posedge clk); #1;
    axis.tready = 1'b0;
    base = beats_seen;
    pushFrame(8'h10);
    strobeFrame(8'h10, 2);
    pat = 4'b1001;
    for (int c = 0; c < 200 && beats_seen < base + 8; c++) begin
      @(posedge clk); #1;
      axis.tready = pat[c % 4];
    end
    if (beats_seen < base + 8) failNow("backpressure_timeout");
    axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back frames with no drops
    $display("[TB] back-to-back");
    base = beats_seen;
    pushFrame(8'h40);
    pushFrame(8'h48);
    pushFrame(8'h50);
    for (int i = 0; i < 24; i++) applyStimulus(8'h40 + 8'(i), 2);
    waitBeats(base + 24, 200, "back_to_back_timeout");
    #1;
    checkOutput("back_to_back_drop_count", 32'(dc), 32'd0);
    checkOutput("back_to_back_overflow_pulses", 32'(ovf_count), 32'd0);

    // Overflow: two frames queued under backpressure, four samples dropped
    $display("[TB] overflow");
    @(posedge clk); #1;
    axis.tready = 1'b0;
    base     = beats_seen;
    ovf_base = ovf_count;
    for (int i = 0; i < 20; i++) applyStimulus(8'(i), 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("overflow_pulses", 32'(ovf_count - ovf_base), 32'd4);
    checkOutput("overflow_drop_count", 32'(dc), 32'd4);
    checkOutput("overflow_busy", 32'(busy), 32'd1);
    checkOutput("overflow_tvalid", 32'(axis.tvalid), 32'd1);
    pushFrame(8'h00);
    pushFrame(8'h08);
    axis.tready = 1'b1;
    waitBeats(base + 16, 100, "overflow_drain_timeout");
    #1;
    base = beats_seen;
    pushFrame(8'd20);
    strobeFrame(8'd20, 2);
    waitBeats(base + 8, 100, "post_overflow_frame_timeout");
    #1;
    checkOutput("post_overflow_drop_count", 32'(dc), 32'd4);

    // Reset in the middle of a streaming frame
    $display("[TB] reset mid-frame");
    base = beats_seen;
    pushFrame(8'h90);
    strobeFrame(8'h90, 2);
    waitBeats(base + 3, 100, "mid_frame_timeout");
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("midreset_tvalid", 32'(axis.tvalid), 32'd0);
    checkOutput("midreset_tlast", 32'(axis.tlast), 32'd0);
    checkOutput("midreset_tdata", axis.tdata, 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_drop_count", 32'(dc), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = beats_seen;
    pushFrame(8'hA0);
    strobeFrame(8'hA0, 1);
    waitBeats(base + 8, 100, "after_reset_frame_timeout");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("final_tvalid", 32'(axis.tvalid), 32'd0);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
